// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response plus the decode-side
// head-of-queue view and control (stall/redirect).
interface fetch_prefetch_queue_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_rvalid;
   logic               stall;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic [INSTR_W-1:0] instr_out;
   logic [ADDR_W-1:0]  pc_out;
   logic               valid_out;
   logic               halt;
   logic [OCC_W-1:0]   occupancy;

   // master = the fetch unit, slave = memory + decode environment
   modport master (
      output imem_req, imem_addr, instr_out, pc_out, valid_out, halt, occupancy,
      input  imem_rdata, imem_rvalid, stall, redirect, redirect_pc
   );
   modport slave (
      input  imem_req, imem_addr, instr_out, pc_out, valid_out, halt, occupancy,
      output imem_rdata, imem_rvalid, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetcher feeding an in-order queue to decode; drops
// wrong-path responses after redirect and stops fetching once HALT is queued.
module fetch_prefetch_queue #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter int                DEPTH    = 4,
   parameter int                MAX_OUT  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                    clk,
   input logic                    reset,
   fetch_prefetch_queue_if.master bus
);
   localparam int         PTR_W   = $clog2(DEPTH);
   localparam int         OCC_W   = $clog2(DEPTH + 1);
   localparam int         OUT_W   = $clog2(MAX_OUT + 1);
   localparam logic [3:0] OP_HALT = 4'hF;

   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0]  pc_q    [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [OCC_W-1:0]   count;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  resp_pc;
   logic [OUT_W-1:0]   outstanding;
   logic [OUT_W-1:0]   drop_cnt;
   logic               started;
   logic               fetch_stop;
   logic               halt_q;

   logic issue, rsp_keep, enq, deq, head_halt, valid;

   always_comb begin
      valid     = (count != '0);
      head_halt = (instr_q[rd_ptr][INSTR_W-1 -: 4] == OP_HALT);
      // Budget counts in-flight words as already occupying a slot, so the queue cannot overflow.
      issue     = started && !bus.redirect && !fetch_stop && !halt_q
                  && (int'(outstanding) < MAX_OUT)
                  && (int'(count) + int'(outstanding) < DEPTH);
      rsp_keep  = bus.imem_rvalid && (drop_cnt == '0) && !fetch_stop;
      enq       = !bus.redirect && rsp_keep;
      deq       = !bus.redirect && valid && !bus.stall;
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (enq) begin
         instr_q[wr_ptr] <= bus.imem_rdata;
         pc_q[wr_ptr]    <= resp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         started     <= 1'b0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         fetch_stop  <= 1'b0;
         halt_q      <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (bus.redirect) begin
         // Everything still in flight is wrong-path; count it for discard.
         started     <= 1'b1;
         fetch_pc    <= bus.redirect_pc;
         resp_pc     <= bus.redirect_pc;
         outstanding <= outstanding - OUT_W'(bus.imem_rvalid);
         drop_cnt    <= outstanding - OUT_W'(bus.imem_rvalid);
         fetch_stop  <= 1'b0;
         halt_q      <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         started <= 1'b1;
         if (issue)
            fetch_pc <= fetch_pc + ADDR_W'(1);
         outstanding <= outstanding + OUT_W'(issue) - OUT_W'(bus.imem_rvalid);
         // resp_pc tracks the PC of the next right-path response.
         if (bus.imem_rvalid) begin
            if (drop_cnt != '0)
               drop_cnt <= drop_cnt - OUT_W'(1);
            else
               resp_pc <= resp_pc + ADDR_W'(1);
         end
         if (enq) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (bus.imem_rdata[INSTR_W-1 -: 4] == OP_HALT)
               fetch_stop <= 1'b1;
         end
         if (deq && head_halt) begin
            halt_q <= 1'b1;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (deq)
               rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + OCC_W'(enq) - OCC_W'(deq);
         end
      end
   end

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc;
   assign bus.valid_out = valid;
   assign bus.instr_out = valid ? instr_q[rd_ptr] : '0;
   assign bus.pc_out    = valid ? pc_q[rd_ptr] : '0;
   assign bus.halt      = halt_q;
   assign bus.occupancy = count;
endmodule
